// File: rtl/id_ex_stage_if.sv
// ID/EX stage bus: decoded ID fields, the MEM/WB forwarding sources and the EX-side ALU operands.
// The pipeline-side logic uses master; the id_ex_stage register uses slave.
interface id_ex_stage_if;
   logic        stall;
   logic [31:0] id_pc;
   logic [4:0]  id_rs_addr;
   logic [4:0]  id_rt_addr;
   logic [31:0] id_rs_data;
   logic [31:0] id_rt_data;
   logic [31:0] id_imm;
   logic [3:0]  id_alu_op;
   logic        id_alu_src_b;
   logic [4:0]  id_wr_addr;
   logic        id_reg_write;
   logic [4:0]  mem_wr_addr;
   logic        mem_reg_write;
   logic [31:0] mem_fwd_data;
   logic [4:0]  wb_wr_addr;
   logic        wb_reg_write;
   logic [31:0] wb_fwd_data;
   logic [3:0]  ex_alu_op;
   logic [31:0] ex_in_a;
   logic [31:0] ex_in_b;
   logic [31:0] ex_rt_val;
   logic [31:0] ex_pc;
   logic [4:0]  ex_wr_addr;
   logic        ex_reg_write;
   logic        ex_valid;

   modport master (
      output stall, id_pc, id_rs_addr, id_rt_addr, id_rs_data, id_rt_data, id_imm,
             id_alu_op, id_alu_src_b, id_wr_addr, id_reg_write,
             mem_wr_addr, mem_reg_write, mem_fwd_data, wb_wr_addr, wb_reg_write, wb_fwd_data,
      input  ex_alu_op, ex_in_a, ex_in_b, ex_rt_val, ex_pc, ex_wr_addr, ex_reg_write, ex_valid
   );

   modport slave (
      input  stall, id_pc, id_rs_addr, id_rt_addr, id_rs_data, id_rt_data, id_imm,
             id_alu_op, id_alu_src_b, id_wr_addr, id_reg_write,
             mem_wr_addr, mem_reg_write, mem_fwd_data, wb_wr_addr, wb_reg_write, wb_fwd_data,
      output ex_alu_op, ex_in_a, ex_in_b, ex_rt_val, ex_pc, ex_wr_addr, ex_reg_write, ex_valid
   );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with bubble insertion on stall and EX-stage operand forwarding
// from MEM (newest) and WB. There is no handshake: ID is captured on every clock edge.
module id_ex_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
   input logic           clk,
   input logic           reset,
   id_ex_stage_if.slave  bus
);

   logic [31:0] pc_q,        pc_d;
   logic [4:0]  rs_addr_q,   rs_addr_d;
   logic [4:0]  rt_addr_q,   rt_addr_d;
   logic [31:0] rs_data_q,   rs_data_d;
   logic [31:0] rt_data_q,   rt_data_d;
   logic [31:0] imm_q,       imm_d;
   logic [3:0]  alu_op_q,    alu_op_d;
   logic        alu_src_b_q, alu_src_b_d;
   logic [4:0]  wr_addr_q,   wr_addr_d;
   logic        reg_write_q, reg_write_d;
   logic        valid_q,     valid_d;

   logic [31:0] rs_fwd;
   logic [31:0] rt_fwd;

   // A bubble keeps the PC of the held instruction but is otherwise an all-zero NOP.
   always_comb begin
      pc_d        = bus.id_pc;
      rs_addr_d   = 5'd0;
      rt_addr_d   = 5'd0;
      rs_data_d   = 32'd0;
      rt_data_d   = 32'd0;
      imm_d       = 32'd0;
      alu_op_d    = 4'd0;
      alu_src_b_d = 1'b0;
      wr_addr_d   = 5'd0;
      reg_write_d = 1'b0;
      valid_d     = 1'b0;
      if (!bus.stall) begin
         rs_addr_d   = bus.id_rs_addr;
         rt_addr_d   = bus.id_rt_addr;
         rs_data_d   = bus.id_rs_data;
         rt_data_d   = bus.id_rt_data;
         imm_d       = bus.id_imm;
         alu_op_d    = bus.id_alu_op;
         alu_src_b_d = bus.id_alu_src_b;
         wr_addr_d   = bus.id_wr_addr;
         reg_write_d = bus.id_reg_write;
         valid_d     = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q        <= RESET_PC;
         rs_addr_q   <= 5'd0;
         rt_addr_q   <= 5'd0;
         rs_data_q   <= 32'd0;
         rt_data_q   <= 32'd0;
         imm_q       <= 32'd0;
         alu_op_q    <= 4'd0;
         alu_src_b_q <= 1'b0;
         wr_addr_q   <= 5'd0;
         reg_write_q <= 1'b0;
         valid_q     <= 1'b0;
      end else begin
         pc_q        <= pc_d;
         rs_addr_q   <= rs_addr_d;
         rt_addr_q   <= rt_addr_d;
         rs_data_q   <= rs_data_d;
         rt_data_q   <= rt_data_d;
         imm_q       <= imm_d;
         alu_op_q    <= alu_op_d;
         alu_src_b_q <= alu_src_b_d;
         wr_addr_q   <= wr_addr_d;
         reg_write_q <= reg_write_d;
         valid_q     <= valid_d;
      end
   end

   // $0 is hard-wired zero, so a pending write to it must never be bypassed.
   function automatic logic [31:0] fwd_sel(
      input logic [4:0]  addr,
      input logic [31:0] reg_data,
      input logic        mem_we,
      input logic [4:0]  mem_addr,
      input logic [31:0] mem_data,
      input logic        wb_we,
      input logic [4:0]  wb_addr,
      input logic [31:0] wb_data
   );
      logic [31:0] result;
      result = reg_data;
      if (addr != 5'd0) begin
         if (mem_we && (mem_addr == addr)) begin
            result = mem_data;
         end else if (wb_we && (wb_addr == addr)) begin
            result = wb_data;
         end
      end
      return result;
   endfunction

   always_comb begin
      rs_fwd = fwd_sel(rs_addr_q, rs_data_q, bus.mem_reg_write, bus.mem_wr_addr, bus.mem_fwd_data,
                       bus.wb_reg_write, bus.wb_wr_addr, bus.wb_fwd_data);
      rt_fwd = fwd_sel(rt_addr_q, rt_data_q, bus.mem_reg_write, bus.mem_wr_addr, bus.mem_fwd_data,
                       bus.wb_reg_write, bus.wb_wr_addr, bus.wb_fwd_data);
   end

   assign bus.ex_in_a      = rs_fwd;
   assign bus.ex_in_b      = alu_src_b_q ? imm_q : rt_fwd;
   assign bus.ex_rt_val    = rt_fwd;
   assign bus.ex_alu_op    = alu_op_q;
   assign bus.ex_pc        = pc_q;
   assign bus.ex_wr_addr   = wr_addr_q;
   assign bus.ex_reg_write = reg_write_q;
   assign bus.ex_valid     = valid_q;

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register plus EX-stage operand forwarding for the five-stage MIPS core. It captures the decoded instruction from ID on each clock. It inserts a bubble when the hazard unit stalls ID. It drives the EX-stage ALU's `op`, `inA` and `inB` inputs from the registered operands, bypassed with the newest EX/MEM or MEM/WB result.

## Interface
- `RESET_PC`, 32'h0000_3000, value loaded into `ex_pc` on reset.
- `clk`  in  1  system clock; all state updates on posedge.
- `reset`  in  1  synchronous, active-high reset.
- `stall`  in  1  hazard unit holds ID/IF; this block loads a bubble instead of ID contents.
- `id_pc`  in  32  PC of instruction in ID.
- `id_rs_addr`, `id_rt_addr`  in  5  source register numbers.
- `id_rs_data`, `id_rt_data`  in  32  GRF read data, already WB→ID bypassed.
- `id_imm`  in  32  extended immediate; zero-extended imm16 for ori/lui, sign-extended otherwise.
- `id_alu_op`  in  4  ALU op: 0000 ADDU, 0001 SUBU, 0010 AND, 0011 OR, 0100 LUI.
- `id_alu_src_b`  in  1  0: B = rt, 1: B = imm.
- `id_wr_addr`  in  5  destination register.
- `id_reg_write`  in  1  instruction writes GRF.
- `mem_wr_addr`  in  5  destination of the instruction in MEM.
- `mem_reg_write`  in  1  MEM instruction writes GRF.
- `mem_fwd_data`  in  32  value forwardable from MEM.
- `wb_wr_addr`  in  5  destination of the instruction in WB.
- `wb_reg_write`  in  1  WB instruction writes GRF.
- `wb_fwd_data`  in  32  value forwardable from WB.
- `ex_alu_op`  out  4  to ALU `op`.
- `ex_in_a`  out  32  to ALU `inA`; forwarded rs.
- `ex_in_b`  out  32  to ALU `inB`; forwarded rt or imm.
- `ex_rt_val`  out  32  forwarded rt, always; store data for MEM.
- `ex_pc`  out  32  PC of EX instruction.
- `ex_wr_addr`  out  5  registered destination.
- `ex_reg_write`  out  1  registered write enable.
- `ex_valid`  out  1  1 = real instruction, 0 = bubble/reset.

## Operation
- Registered fields are pc, rs/rt addr, rs/rt data, imm, alu_op, alu_src_b, wr_addr, reg_write and valid.
- Priority per edge is reset > stall > load.
  - reset: every field is 0, except pc = `RESET_PC`.
  - stall: bubble. All fields are 0, except pc, which loads `id_pc`. The bubble behaves as a NOP: alu_op ADDU, reg_write 0, wr_addr 0, valid 0.
  - otherwise: load all `id_*` fields and set valid = 1.
- Forwarding is combinational, evaluated separately for the registered rs and for the registered rt.
  - Registered address == 0: use the registered data unchanged. $0 is never forwarded.
  - Else if `mem_reg_write` and `mem_wr_addr` == address: use `mem_fwd_data`. MEM has priority over WB.
  - Else if `wb_reg_write` and `wb_wr_addr` == address: use `wb_fwd_data`.
  - Else use the registered data.
- `ex_in_a` = forwarded rs.
- `ex_in_b` = registered imm if alu_src_b, else forwarded rt.
- `ex_rt_val` = forwarded rt regardless of alu_src_b.
- `ex_alu_op`, `ex_wr_addr`, `ex_reg_write`, `ex_pc` and `ex_valid` come directly from the register.
- Width rules: all data paths are 32 bits, with no truncation or extension here. Extension is ID's job.
- This block never stalls on its own. Load-use and other unresolvable hazards are detected upstream and arrive as `stall`.

## Timing
- Latency: ID inputs sampled at edge N appear on the `ex_*` outputs after edge N and stay valid through cycle N+1.
- Forwarding path: `mem_*` / `wb_*` inputs affect `ex_in_a`, `ex_in_b` and `ex_rt_val` in the same cycle, with no register in the path.
- Reset values: `ex_alu_op`=0, `ex_wr_addr`=0, `ex_reg_write`=0, `ex_valid`=0, `ex_pc`=`RESET_PC`. With no active forwarding, `ex_in_a`, `ex_in_b` and `ex_rt_val` are 0.
- Reset asserted while stall=1: reset wins, and pc = `RESET_PC`.
- Consecutive stall cycles: each cycle loads a fresh bubble.
- The first cycle after stall deasserts loads the held ID instruction.
- MEM and WB both match the same register: MEM data is used.
- A write to $0 by either stage is never forwarded, even if its data is nonzero.

## Test plan
- Reset: assert reset for 2 cycles with `id_*` nonzero → `ex_pc`=32'h0000_3000, `ex_valid`=0, `ex_reg_write`=0, `ex_in_a`=0.
- Plain load: id_rs_data=5, id_rt_data=7, alu_op=0001, src_b=0, no forwarding matches → next cycle `ex_in_a`=5, `ex_in_b`=7, `ex_alu_op`=0001, `ex_valid`=1.
- Forwarding priority: registered rs=8. mem_wr_addr=8 with data 32'hAAAA_0000, and wb_wr_addr=8 with data 32'h1234 → `ex_in_a`=32'hAAAA_0000. Drop `mem_reg_write` → `ex_in_a`=32'h1234 in the same cycle.
- $0 guard: registered rt=0, rt data=0, mem_wr_addr=0, mem_reg_write=1, data 32'hFFFF_FFFF → `ex_in_b`=0 and `ex_rt_val`=0.
- Immediate and store path: lui with imm=32'h0000_ABCD, src_b=1, registered rt=9 forwarded from WB as 42 → `ex_in_b`=32'h0000_ABCD and `ex_rt_val`=42.
- Stall bubble: stall=1 for 2 cycles with id_reg_write=1 → both cycles show `ex_valid`=0, `ex_reg_write`=0, `ex_alu_op`=0, `ex_pc`=`id_pc`. Deassert stall → held instruction appears with `ex_valid`=1.
